// File: rtl/mem_defs.sv
// rtl/mem_defs.sv - shared memory access size codes and data-port FSM states
package mem_defs;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/data_ram.sv
// rtl/data_ram.sv - synchronous-read block RAM with byte-lane write enables
module data_ram #(
  parameter int ADDR_BITS = 18
) (
  input  logic                 clka,
  input  logic                 ena,
  input  logic [3:0]           wea,
  input  logic [ADDR_BITS-1:0] addra,
  input  logic [31:0]          dina,
  output logic [31:0]          douta
);

  logic [31:0] mem [0:(2**ADDR_BITS)-1];

  // Per-lane write and read-first registered read.
  always_ff @(posedge clka) begin
    if (ena) begin
      for (int i = 0; i < 4; i++) begin
        if (wea[i]) mem[addra][i*8 +: 8] <= dina[i*8 +: 8];
      end
      douta <= mem[addra];
    end
  end

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - MEM-stage data port: lane stores, two-cycle loads, alignment exceptions
module data_memory
  import mem_defs::*;
#(
  parameter int ADDR_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsignedLoad,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        requireStall,
  output logic        loadException,
  output logic        storeException
);

  mem_state_t  state;
  logic [1:0]  off;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        bad;
  logic        good_load;
  logic        good_store;
  logic [3:0]  wea;
  logic [31:0] wdata;
  logic [31:0] douta;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic        unused_addr_bits;

  assign off = addr[1:0];
  assign unused_addr_bits = ^addr[31:ADDR_BITS+2];

  assign bad = ((size == SIZE_HALF) & addr[0])
             | ((size == SIZE_WORD) & (addr[1:0] != 2'b00))
             | (size == 2'b11);

  assign loadException  = en & ~we & bad;
  assign storeException = en & we & bad;

  assign good_load    = en & ~we & ~bad & ~rst;
  // Stores only land from IDLE; WAIT never samples a new request.
  assign good_store   = en & we & ~bad & ~rst & (state == ST_IDLE);
  assign requireStall = (state == ST_IDLE) & good_load;

  // Byte-lane write enables and lane-replicated write data.
  always_comb begin
    wea   = 4'b0000;
    wdata = din;
    case (size)
      SIZE_BYTE: begin
        wea   = 4'b0001 << off;
        wdata = {4{din[7:0]}};
      end
      SIZE_HALF: begin
        wea   = 4'b0011 << {off[1], 1'b0};
        wdata = {2{din[15:0]}};
      end
      SIZE_WORD: wea = 4'b1111;
      default:   wea = 4'b0000;
    endcase
    if (!good_store) wea = 4'b0000;
  end

  data_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_data_ram (
    .clka  (clk),
    .ena   (1'b1),
    .wea   (wea),
    .addra (addr[ADDR_BITS+1:2]),
    .dina  (wdata),
    .douta (douta)
  );

  // Load FSM: IDLE launches the RAM read, WAIT presents the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      off_q  <= 2'b00;
      size_q <= SIZE_BYTE;
      uns_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (good_load) begin
            state  <= ST_WAIT;
            off_q  <= off;
            size_q <= size;
            uns_q  <= unsignedLoad;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sel_byte = douta[{off_q, 3'b000} +: 8];
  assign sel_half = off_q[1] ? douta[31:16] : douta[15:0];

  // Extract and extend the loaded lane; zero outside WAIT.
  always_comb begin
    dout = 32'h0;
    if (state == ST_WAIT) begin
      case (size_q)
        SIZE_BYTE: dout = {{24{sel_byte[7] & ~uns_q}}, sel_byte};
        SIZE_HALF: dout = {{16{sel_half[15] & ~uns_q}}, sel_half};
        default:   dout = douta;
      endcase
    end
  end

endmodule
